// File: rtl/vga_timing_if.sv
`timescale 1ns/1ps
// Timing bundle presented by the VGA timing generator to its consumers.
interface vga_timing_if;
    logic        pix_en;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hSync;
    logic        vSync;
    logic        bright;
    logic        frame_tick;
    logic [15:0] frame_count;

    modport master (
        output pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, frame_count
    );

    modport slave (
        input pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// VGA raster timing: pixel-rate enable from a clock divider, h/v counters,
// registered sync/visible decode aligned with the counts, and a frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic          clk,
    input  logic          reset,
    vga_timing_if.master  vga
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0] H_VS     = 10'(H_VIS_START);
    localparam logic [9:0] H_VE     = 10'(H_VIS_END);
    localparam logic [9:0] V_VS     = 10'(V_VIS_START);
    localparam logic [9:0] V_VE     = 10'(V_VIS_END);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             pix_en_q;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             h_wrap;
    logic             v_at_last;
    logic             frame_end;
    logic             hsync_q;
    logic             vsync_q;
    logic             bright_q;
    logic             frame_tick_q;
    logic [15:0]      frame_cnt;

    // Next counts are computed every clk; when pix_en is low they equal the
    // current counts, so the decode below naturally holds between pixels.
    always_comb begin
        div_next  = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        h_wrap    = pix_en_q && (h_cnt >= H_LAST);
        v_at_last = (v_cnt >= V_LAST);
        frame_end = h_wrap && v_at_last;
        h_next    = h_cnt;
        v_next    = v_cnt;
        if (pix_en_q) begin
            h_next = h_wrap ? 10'd0 : h_cnt + 10'd1;
        end
        if (h_wrap) begin
            v_next = v_at_last ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Sync/bright are decoded from the next counts so they change on the
    // same edge as hCount/vCount with no skew.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt      <= '0;
            pix_en_q     <= 1'b0;
            h_cnt        <= 10'd0;
            v_cnt        <= 10'd0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            bright_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            frame_cnt    <= 16'd0;
        end else begin
            div_cnt      <= div_next;
            pix_en_q     <= (div_next == DIV_LAST);
            h_cnt        <= h_next;
            v_cnt        <= v_next;
            hsync_q      <= (h_next >= H_SYNC_W);
            vsync_q      <= (v_next >= V_SYNC_W);
            bright_q     <= (h_next >= H_VS) && (h_next < H_VE) &&
                            (v_next >= V_VS) && (v_next < V_VE);
            frame_tick_q <= frame_end;
            frame_cnt    <= frame_cnt + {15'd0, frame_end};
        end
    end

    assign vga.pix_en      = pix_en_q;
    assign vga.hCount      = h_cnt;
    assign vga.vCount      = v_cnt;
    assign vga.hSync       = hsync_q;
    assign vga.vSync       = vsync_q;
    assign vga.bright      = bright_q;
    assign vga.frame_tick  = frame_tick_q;
    assign vga.frame_count = frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Directed bench: a default-size generator for line-level timing and reset,
// plus a shrunken generator (20x12 pixels, /2) for whole-frame behaviour.
module tb_vga_timing_gen;
    logic clk     = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    vga_timing_if vga_a ();
    vga_timing_if vga_b ();

    vga_timing_gen dut_a (
        .clk   (clk),
        .reset (reset_a),
        .vga   (vga_a)
    );

    vga_timing_gen #(
        .CLK_DIV     (2),
        .H_TOTAL     (20),
        .V_TOTAL     (12),
        .H_SYNC      (3),
        .H_VIS_START (5),
        .H_VIS_END   (17),
        .V_SYNC      (2),
        .V_VIS_START (3),
        .V_VIS_END   (10)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .vga   (vga_b)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_pix_en"},      32'(vga_a.pix_en),      32'd0);
        check({tag, "_hcount"},      32'(vga_a.hCount),      32'd0);
        check({tag, "_vcount"},      32'(vga_a.vCount),      32'd0);
        check({tag, "_hsync"},       32'(vga_a.hSync),       32'd0);
        check({tag, "_vsync"},       32'(vga_a.vSync),       32'd0);
        check({tag, "_bright"},      32'(vga_a.bright),      32'd0);
        check({tag, "_frame_tick"},  32'(vga_a.frame_tick),  32'd0);
        check({tag, "_frame_count"}, 32'(vga_a.frame_count), 32'd0);
    endtask

    task automatic wait_pos_a(input int h, input int v, input int budget, input string tag);
        int n;
        n = 0;
        while (!(int'(vga_a.hCount) == h && int'(vga_a.vCount) == v) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_h"}, 32'(vga_a.hCount), 32'(h));
        check({tag, "_v"}, 32'(vga_a.vCount), 32'(v));
    endtask

    initial begin
        int exp_pix;
        int exp_h;
        int exp_v;
        int exp_hs;
        int exp_vs;
        int exp_br;
        int p;
        int n;
        int hs_low;
        int br_cnt;
        int ticks;

        // Reset state, with the clock running
        repeat (3) tick();
        check_zero_a("reset");
        check("reset_b_hcount",      32'(vga_b.hCount),      32'd0);
        check("reset_b_frame_count", 32'(vga_b.frame_count), 32'd0);

        // First pixel steps after release: pix_en in clks 4, 8, 12
        @(negedge clk);
        reset_a = 1'b0;
        check("rel_pix_en_0", 32'(vga_a.pix_en), 32'd0);
        check("rel_hcount_0", 32'(vga_a.hCount), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_pix = (k % 4 == 3) ? 1 : 0;
            exp_h   = k / 4;
            check("rel_pix_en", 32'(vga_a.pix_en), 32'(exp_pix));
            check("rel_hcount", 32'(vga_a.hCount), 32'(exp_h));
        end

        // Line wrap: (799,10) -> (0,11)
        force dut_a.v_cnt = 10'd10;
        tick();
        release dut_a.v_cnt;
        wait_pos_a(799, 10, 4000, "wrap_pre");
        check("wrap_pre_hsync",  32'(vga_a.hSync),  32'd1);
        check("wrap_pre_bright", 32'(vga_a.bright), 32'd0);
        n = 0;
        while (vga_a.hCount == 10'd799 && n < 8) begin
            tick();
            n++;
        end
        check("wrap_hcount",     32'(vga_a.hCount),     32'd0);
        check("wrap_vcount",     32'(vga_a.vCount),     32'd11);
        check("wrap_hsync",      32'(vga_a.hSync),      32'd0);
        check("wrap_vsync",      32'(vga_a.vSync),      32'd1);
        check("wrap_bright",     32'(vga_a.bright),     32'd0);
        check("wrap_frame_tick", 32'(vga_a.frame_tick), 32'd0);

        // Full sweep of visible line 100
        force dut_a.v_cnt = 10'd99;
        tick();
        release dut_a.v_cnt;
        wait_pos_a(0, 100, 4000, "sweep_start");
        hs_low = 0;
        br_cnt = 0;
        for (int px = 0; px < 800; px++) begin
            exp_hs = (px >= 96) ? 1 : 0;
            exp_br = (px >= 144 && px < 784) ? 1 : 0;
            check("sweep_hcount", 32'(vga_a.hCount), 32'(px));
            check("sweep_vcount", 32'(vga_a.vCount), 32'd100);
            check("sweep_hsync",  32'(vga_a.hSync),  32'(exp_hs));
            check("sweep_bright", 32'(vga_a.bright), 32'(exp_br));
            if (vga_a.hSync == 1'b0) hs_low++;
            if (vga_a.bright == 1'b1) br_cnt++;
            for (int s = 0; s < 3; s++) begin
                tick();
                check("sweep_hold_hcount", 32'(vga_a.hCount), 32'(px));
            end
            tick();
        end
        check("sweep_hsync_low_total", 32'(hs_low), 32'd96);
        check("sweep_bright_total",    32'(br_cnt), 32'd640);
        check("sweep_end_hcount", 32'(vga_a.hCount), 32'd0);
        check("sweep_end_vcount", 32'(vga_a.vCount), 32'd101);

        // Reset mid-frame at (400,300), asserted between clock edges
        force dut_a.v_cnt = 10'd299;
        tick();
        release dut_a.v_cnt;
        wait_pos_a(400, 300, 5200, "midrst_pos");
        reset_a = 1'b1;
        #1;
        check_zero_a("midrst");
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        ticks = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (vga_a.frame_tick == 1'b1) ticks++;
        end
        check("midrst_tick_total",  32'(ticks),              32'd0);
        check("midrst_frame_count", 32'(vga_a.frame_count), 32'd0);
        check("midrst_hcount",      32'(vga_a.hCount),      32'd25);
        check("midrst_vcount",      32'(vga_a.vCount),      32'd0);

        // Whole frame on the small generator: 240 pixels x 2 clks
        @(negedge clk);
        reset_b = 1'b0;
        ticks = 0;
        for (int c = 1; c <= 482; c++) begin
            tick();
            p      = (c / 2) % 240;
            exp_h  = p % 20;
            exp_v  = p / 20;
            exp_hs = (exp_h >= 3) ? 1 : 0;
            exp_vs = (exp_v >= 2) ? 1 : 0;
            exp_br = (exp_h >= 5 && exp_h < 17 && exp_v >= 3 && exp_v < 10) ? 1 : 0;
            check("frame_hcount",      32'(vga_b.hCount),      32'(exp_h));
            check("frame_vcount",      32'(vga_b.vCount),      32'(exp_v));
            check("frame_hsync",       32'(vga_b.hSync),       32'(exp_hs));
            check("frame_vsync",       32'(vga_b.vSync),       32'(exp_vs));
            check("frame_bright",      32'(vga_b.bright),      32'(exp_br));
            check("frame_tick",        32'(vga_b.frame_tick),  (c == 480) ? 32'd1 : 32'd0);
            check("frame_count",       32'(vga_b.frame_count), (c >= 480) ? 32'd1 : 32'd0);
            if (vga_b.frame_tick == 1'b1) ticks++;
        end
        check("frame_tick_total", 32'(ticks), 32'd1);

        // frame_count wrap from 0xFFFF
        force dut_b.frame_cnt = 16'hFFFF;
        tick();
        release dut_b.frame_cnt;
        check("wrap16_preload", 32'(vga_b.frame_count), 32'h0000FFFF);
        ticks = 0;
        for (int c = 484; c <= 961; c++) begin
            tick();
            if (vga_b.frame_tick == 1'b1) ticks++;
            check("wrap16_tick", 32'(vga_b.frame_tick), (c == 960) ? 32'd1 : 32'd0);
            if (c == 960) begin
                check("wrap16_count",  32'(vga_b.frame_count), 32'd0);
                check("wrap16_hcount", 32'(vga_b.hCount),      32'd0);
                check("wrap16_vcount", 32'(vga_b.vCount),      32'd0);
            end
        end
        check("wrap16_tick_total", 32'(ticks),              32'd1);
        check("wrap16_count_after", 32'(vga_b.frame_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4, meaning system clocks per pixel (power of two, 2..8).
REQ-002 SHALL provide parameter H_TOTAL, default 800, meaning pixels per line including blanking.
REQ-003 SHALL provide parameter V_TOTAL, default 525, meaning lines per frame.
REQ-004 SHALL provide parameters H_SYNC 96 / H_VIS_START 144 / H_VIS_END 784 and V_SYNC 2 / V_VIS_START 35 / V_VIS_END 515, meaning sync width and visible window (start inclusive, end exclusive).
REQ-005 SHALL have port clk, input, 1, the single system clock (100 MHz); all state is in this domain.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port pix_en, output, 1, one-clk pulse marking each pixel step.
REQ-008 SHALL have port hCount, output, 10, horizontal pixel index 0..H_TOTAL-1.
REQ-009 SHALL have port vCount, output, 10, line index 0..V_TOTAL-1.
REQ-010 SHALL have port hSync, output, 1, horizontal sync, active low.
REQ-011 SHALL have port vSync, output, 1, vertical sync, active low.
REQ-012 SHALL have port bright, output, 1, high inside the visible window.
REQ-013 SHALL have port frame_tick, output, 1, one-clk pulse at start of each frame.
REQ-014 SHALL have port frame_count, output, 16, number of completed frames.

Function
REQ-015 SHALL count a divider 0..CLK_DIV-1 every clk, wrapping to 0; pix_en high exactly on the clk where divider equals CLK_DIV-1.
REQ-016 SHALL, on the clk where pix_en is high, advance hCount by 1; hCount H_TOTAL-1 wraps to 0 on that edge.
REQ-017 SHALL advance vCount by 1 only on the edge where hCount wraps; vCount V_TOTAL-1 wraps to 0 on that edge.
REQ-018 SHALL hold hCount, vCount and all decoded outputs constant on clks where pix_en is low.
REQ-019 SHALL register hSync, vSync, bright so they update on the same edge as the counts and always equal the decode of the currently output counts (zero-cycle skew vs hCount/vCount).
REQ-020 SHALL drive hSync = 0 iff hCount < H_SYNC; vSync = 0 iff vCount < V_SYNC.
REQ-021 SHALL drive bright = 1 iff H_VIS_START <= hCount < H_VIS_END and V_VIS_START <= vCount < V_VIS_END.
REQ-022 SHALL pulse frame_tick for exactly one clk, on the edge where counts move from (H_TOTAL-1, V_TOTAL-1) to (0, 0).
REQ-023 SHALL increment frame_count on the same edge frame_tick rises, wrapping 0xFFFF to 0x0000 without stall.
REQ-024 SHALL never present hCount >= H_TOTAL or vCount >= V_TOTAL, including immediately after reset.
REQ-025 SHALL use only unsigned 10-bit count arithmetic; no output depends on widths beyond those declared.

Reset
REQ-026 SHALL, while reset is high, asynchronously force divider 0, hCount 0, vCount 0, frame_count 0, pix_en 0, frame_tick 0, bright 0, hSync 0, vSync 0.
REQ-027 SHALL, after reset deassertion, produce first pix_en on the CLK_DIV-th rising clk edge, resuming normal counting from (0, 0).
REQ-028 SHALL, on reset asserted mid-line or mid-frame, abandon the frame with no frame_tick and no frame_count increment.
REQ-029 SHALL NOT generate frame_tick on reset release; first frame_tick occurs at the end of the first full frame (H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clks at defaults).

Verification
REQ-030 SHALL cover: release reset, run 12 clks -> pix_en high on clks 4, 8, 12 only; hCount steps 0->1->2->3.
REQ-031 SHALL cover: run to hCount 799, vCount 10, then next pix_en -> hCount 0, vCount 11, hSync 0, bright 0.
REQ-032 SHALL cover: sweep one line at vCount 100 -> hSync low for hCount 0..95, bright high exactly for hCount 144..783 (640 pixels).
REQ-033 SHALL cover: run full frame -> vSync low for vCount 0..1 only, bright lines 35..514 (480 lines), one frame_tick at (799,524)->(0,0), frame_count 1.
REQ-034 SHALL cover: assert reset at hCount 400, vCount 300 between clk edges -> all outputs zero immediately, frame_count unchanged at 0 after release until next full frame.
REQ-035 SHALL cover: preload frame_count 0xFFFF via force then complete a frame -> frame_count 0x0000, frame_tick one clk wide.
